hub75_scan_reader: RTL and testbench
====================================

Name: hub75_scan_reader

Overview:
- Reads the 24-bit RGB framebuffer through one read-only RAM port (addr / re / 1-cycle registered data) and drives a HUB75 LED panel.
- Scans ROWS/2 row pairs (upper and lower half) and shows each row with binary-coded modulation (BCM) over BIT_DEPTH bit planes.
- Sits between the framebuffer's port B and the panel connector.

Parameters:
- COLS, 48, pixels per panel row.
- ROWS, 48, panel rows. Must be even; scan is ROWS/2.
- ADDR_W, 12, framebuffer address width.
- BIT_DEPTH, 8, bit planes per channel (1..8), taken MSB-aligned from each 8-bit channel.
- BASE_DELAY, 1, oe_n low time in clocks for plane 0. Plane p shows for BASE_DELAY<<p clocks.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  scan enable
- mem_addr  out  ADDR_W  framebuffer read address
- mem_re  out  1  framebuffer read enable
- mem_dat  in  24  read data, valid the cycle after mem_re; {R[23:16],G[15:8],B[7:0]}
- r0,g0,b0  out  1 each  upper-half colour bits
- r1,g1,b1  out  1 each  lower-half colour bits
- sclk  out  1  panel shift clock
- lat  out  1  panel latch
- oe_n  out  1  panel output enable, active low
- row_addr  out  $clog2(ROWS/2)  panel row select (A..E)
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst=0, asynchronous) values:
  - mem_addr=0, mem_re=0, rgb outputs=0, sclk=0, lat=0, oe_n=1, row_addr=0, frame_done=0.
  - Internal row=0, col=0, plane=0, state IDLE.
- FSM states: IDLE, FETCH_U, FETCH_L, SETUP, CLK, LATCH, SHOW.
- IDLE: all outputs held at reset values. en=1 -> FETCH_U.
- FETCH_U: mem_addr = row*COLS+col, mem_re=1.
- FETCH_L: mem_addr = (row+ROWS/2)*COLS+col, mem_re=1. Capture mem_dat into the upper pixel register.
- SETUP: mem_re=0. Capture mem_dat into the lower pixel register. Register r0/g0/b0 and r1/g1/b1 as bit (plane+8-BIT_DEPTH) of each channel. sclk=0.
- CLK: sclk=1, data held. If col==COLS-1: col<=0, go to LATCH. Otherwise col++, go to FETCH_U.
- Per column cost: exactly 4 clocks. sclk is low except in CLK.
- LATCH: lat=1 for one cycle, oe_n=1, row_addr<=row.
- SHOW: oe_n=0 for exactly BASE_DELAY<<plane clocks, then oe_n=1. On exit:
  - plane<BIT_DEPTH-1: plane++.
  - Otherwise: plane=0 and row++.
  - row wraps from ROWS/2-1 to 0; frame_done=1 for exactly that exit cycle.
  - Next state is FETCH_U, or IDLE if en=0.
- No shift/display overlap: oe_n=1 throughout FETCH_U..LATCH.
- Plane period: 4*COLS+1+(BASE_DELAY<<plane) clocks.
- en=0 mid-plane: the current plane finishes shifting, latching and showing, then the FSM enters IDLE.
  - row, plane and col are retained; re-enable resumes at that position with col=0.
- Address arithmetic is done in ADDR_W bits. It never exceeds ROWS*COLS-1.
- rst asserted mid-operation: all outputs take reset values immediately; oe_n goes high asynchronously.

Test Plan:
Common setup for all scenarios: COLS=4, ROWS=4, BIT_DEPTH=2, BASE_DELAY=2, behavioural RAM with 1-cycle registered read.
1. Reset: hold rst=0 with en=1, then release with en=0. Required: oe_n=1, sclk=0, lat=0, mem_re=0, row_addr=0 throughout; state stays IDLE.
2. Address order: en=1 from reset. Required:
   - mem_re addresses for row 0 of each plane are 0,8,1,9,2,10,3,11.
   - Row 1 addresses are 4,12,5,13,6,14,7,15.
   - Exactly 4 sclk rises per plane.
3. Plane bits: mem[0]=24'hC04080, mem[8]=24'h00FF01.
   - Plane 0 (bit 6) at the first sclk rise: r0=1,g0=1,b0=0; r1=0,g1=1,b1=0.
   - Plane 1 (bit 7): r0=1,g0=0,b0=1; r1=0,g1=1,b1=0.
4. BCM timing:
   - lat is high for 1 cycle, one cycle after the 4th CLK of each plane.
   - oe_n is low 2 clocks for plane 0 and 4 clocks for plane 1.
   - row_addr changes 0->1 at the row 1 plane 0 latch.
5. Frame: free-run 3 frames. Required:
   - frame_done pulses every 80 clocks in steady state (2 rows × (17+2 + 17+4)).
   - row_addr wraps 1->0.
6. Interruptions:
   - Drop en at the 2nd column of row 1, plane 0: plane completes (remaining sclks, lat, 2-clock oe_n), then IDLE with oe_n=1 and no further mem_re. Re-raise en: fetch starts at address 4 with plane 1.
   - Assert rst during SHOW: oe_n=1 within the same cycle.

Source files
------------

// File: rtl/hub75_scan_reader.sv
// HUB75 panel scanner: walks the framebuffer one row pair at a time, shifts each
// column out on sclk, latches the row and shows it with binary-coded modulation.
module hub75_scan_reader #(
  parameter  int COLS       = 48,
  parameter  int ROWS       = 48,
  parameter  int ADDR_W     = 12,
  parameter  int BIT_DEPTH  = 8,
  parameter  int BASE_DELAY = 1,
  localparam int RA_W       = (ROWS > 2) ? $clog2(ROWS/2) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [23:0]       mem_dat,
  output logic              r0,
  output logic              g0,
  output logic              b0,
  output logic              r1,
  output logic              g1,
  output logic              b1,
  output logic              sclk,
  output logic              lat,
  output logic              oe_n,
  output logic [RA_W-1:0]   row_addr,
  output logic              frame_done
);

  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = $clog2(BASE_DELAY << (BIT_DEPTH-1)) + 1;

  typedef enum logic [2:0] {IDLE, FETCH_U, FETCH_L, SETUP, CLK, LATCH, SHOW} state_t;

  state_t            state_q, state_d;
  logic [RA_W-1:0]   row_q, row_d, row_addr_q, row_addr_d;
  logic [CW-1:0]     col_q, col_d;
  logic [2:0]        plane_q, plane_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [23:0]       upper_q, upper_d;
  logic [5:0]        rgb_q, rgb_d;

  logic [CNT_W-1:0]  dur;
  logic [2:0]        bidx;
  logic [ADDR_W-1:0] addr_u, addr_l;
  logic              show_last, plane_last, row_last, col_last;

  // Shared decode: plane on-time, bit index inside each channel, pixel addresses
  always_comb begin
    dur        = CNT_W'(BASE_DELAY) << plane_q;
    show_last  = (cnt_q == dur - CNT_W'(1));
    plane_last = (plane_q == 3'(BIT_DEPTH-1));
    row_last   = (row_q == RA_W'(ROWS/2-1));
    col_last   = (col_q == CW'(COLS-1));
    bidx       = plane_q + 3'(8-BIT_DEPTH);
    addr_u     = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
    addr_l     = (ADDR_W'(row_q) + ADDR_W'(ROWS/2)) * ADDR_W'(COLS) + ADDR_W'(col_q);
  end

  // State register; reset lands in IDLE so oe_n rises asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: 4 clocks per column, then latch, then BCM show; en only sampled
  // at the end of a plane so a started plane always completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = en ? FETCH_U : IDLE;
      FETCH_U: state_d = FETCH_L;
      FETCH_L: state_d = SETUP;
      SETUP:   state_d = CLK;
      CLK:     state_d = col_last ? LATCH : FETCH_U;
      LATCH:   state_d = SHOW;
      SHOW:    if (show_last) state_d = en ? FETCH_U : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: pixel capture, column/plane/row counters, show timer
  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    plane_d    = plane_q;
    cnt_d      = cnt_q;
    upper_d    = upper_q;
    rgb_d      = rgb_q;
    row_addr_d = row_addr_q;
    case (state_q)
      FETCH_L: upper_d = mem_dat;
      SETUP:   rgb_d = {upper_q[5'd16 + 5'(bidx)], upper_q[5'd8 + 5'(bidx)], upper_q[5'(bidx)],
                        mem_dat[5'd16 + 5'(bidx)], mem_dat[5'd8 + 5'(bidx)], mem_dat[5'(bidx)]};
      CLK:     col_d = col_last ? '0 : col_q + CW'(1);
      LATCH: begin
        row_addr_d = row_q;
        cnt_d      = '0;
      end
      SHOW: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (show_last) begin
          cnt_d = '0;
          if (!en) rgb_d = '0;
          if (!plane_last) begin
            plane_d = plane_q + 3'd1;
          end else begin
            plane_d = '0;
            row_d   = row_last ? '0 : row_q + RA_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q      <= '0;
      col_q      <= '0;
      plane_q    <= '0;
      cnt_q      <= '0;
      upper_q    <= '0;
      rgb_q      <= '0;
      row_addr_q <= '0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      plane_q    <= plane_d;
      cnt_q      <= cnt_d;
      upper_q    <= upper_d;
      rgb_q      <= rgb_d;
      row_addr_q <= row_addr_d;
    end
  end

  // Outputs decoded from state; oe_n stays high everywhere except SHOW
  always_comb begin
    mem_re     = 1'b0;
    mem_addr   = '0;
    sclk       = 1'b0;
    lat        = 1'b0;
    oe_n       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      FETCH_U: begin mem_re = 1'b1; mem_addr = addr_u; end
      FETCH_L: begin mem_re = 1'b1; mem_addr = addr_l; end
      CLK:     sclk = 1'b1;
      LATCH:   lat  = 1'b1;
      SHOW: begin
        oe_n       = 1'b0;
        frame_done = show_last && plane_last && row_last;
      end
      default: ;
    endcase
  end

  assign {r0, g0, b0, r1, g1, b1} = rgb_q;
  assign row_addr = row_addr_q;

endmodule

// File: tb/tb_hub75_scan_reader.sv
// Bench for hub75_scan_reader: random framebuffer, event-level reference model of
// the scan order (reads, shifts, latch, BCM on-time, frame pulse).
module tb_hub75_scan_reader;
  localparam int COLS = 4, ROWS = 4, AW = 12, BD = 2, BASE = 2;

  logic          clk, rst, en;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [23:0]   mem_dat;
  logic          r0, g0, b0, r1, g1, b1, sclk, lat, oe_n, frame_done;
  logic [0:0]    row_addr;

  hub75_scan_reader #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .BIT_DEPTH(BD), .BASE_DELAY(BASE)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_addr(mem_addr), .mem_re(mem_re), .mem_dat(mem_dat),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1), .sclk(sclk), .lat(lat), .oe_n(oe_n),
    .row_addr(row_addr), .frame_done(frame_done));

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // framebuffer with 1-cycle registered read
  logic [23:0] mem [16];
  always @(posedge clk) if (mem_re) mem_dat <= mem[mem_addr[3:0]];

  // reference model: current (row, plane) and progress inside the plane
  int mr, mp, rd_idx, sclk_cnt, oe_cnt, last_sclk, rd_total, planes_done, dur, bsel, exp_a;
  bit lat_seen, chk_ra, exp_fd, fd_log;
  int fdq[$];
  logic [23:0] u, l;
  logic [5:0]  exp_px;

  initial begin
    mr = 0; mp = 0; rd_idx = 0; sclk_cnt = 0; oe_cnt = 0; last_sclk = 0;
    rd_total = 0; planes_done = 0; lat_seen = 0; chk_ra = 0; fd_log = 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      mr = 0; mp = 0; rd_idx = 0; sclk_cnt = 0; oe_cnt = 0; lat_seen = 0; chk_ra = 0;
    end else begin
      dur    = BASE << mp;
      exp_fd = !oe_n && (oe_cnt + 1 == dur) && (mp == BD-1) && (mr == ROWS/2-1);
      chk("frame_done", frame_done, exp_fd);
      if (fd_log && frame_done) fdq.push_back(cyc);
      if (chk_ra) begin chk("row_addr", row_addr, mr); chk_ra = 0; end
      if (mem_re) begin
        rd_total++;
        exp_a = ((rd_idx % 2) ? mr + ROWS/2 : mr) * COLS + rd_idx / 2;
        chk("rd_addr", mem_addr, exp_a);
        chk("rd_oe", oe_n, 1);
        rd_idx++;
      end
      if (sclk) begin
        chk("sclk_cnt", sclk_cnt < COLS, 1);
        chk("sclk_rd", rd_idx, 2 * (sclk_cnt + 1));
        chk("sclk_oe", oe_n, 1);
        if (sclk_cnt < COLS) begin
          bsel   = mp + 8 - BD;
          u      = mem[mr * COLS + sclk_cnt];
          l      = mem[(mr + ROWS/2) * COLS + sclk_cnt];
          exp_px = {u[16+bsel], u[8+bsel], u[bsel], l[16+bsel], l[8+bsel], l[bsel]};
          chk("pixel", {r0, g0, b0, r1, g1, b1}, exp_px);
          if (mr == 0 && sclk_cnt == 0)
            chk("pixel0", {r0, g0, b0, r1, g1, b1}, (mp == 0) ? 6'b110_010 : 6'b101_010);
        end
        sclk_cnt++;
        last_sclk = cyc;
      end
      if (lat) begin
        chk("lat_sclk", sclk_cnt, COLS);
        chk("lat_gap", cyc - last_sclk, 1);
        chk("lat_once", lat_seen, 0);
        chk("lat_oe", oe_n, 1);
        lat_seen = 1; chk_ra = 1;
      end
      if (!oe_n) begin
        if (oe_cnt == 0) chk("oe_after_lat", lat_seen, 1);
        oe_cnt++;
        if (oe_cnt == dur) begin
          if (mp < BD-1) mp++;
          else begin mp = 0; mr = (mr == ROWS/2-1) ? 0 : mr + 1; end
          rd_idx = 0; sclk_cnt = 0; lat_seen = 0; oe_cnt = 0;
          planes_done++;
        end
      end else if (oe_cnt != 0) begin
        chk("oe_len", oe_cnt, dur);
        oe_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, pd, n0;
    for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
    mem[0] = 24'hC04080;
    mem[8] = 24'h00FF01;
    en = 1'b1; rst = 1'b1;
    #1 rst = 1'b0;

    // reset held with en high, then released with en low
    repeat (4) begin
      @(negedge clk);
      chk("rst_oe", oe_n, 1); chk("rst_sclk", sclk, 0); chk("rst_lat", lat, 0);
      chk("rst_re", mem_re, 0); chk("rst_ra", row_addr, 0); chk("rst_fd", frame_done, 0);
      chk("rst_rgb", {r0, g0, b0, r1, g1, b1}, 0); chk("rst_addr", mem_addr, 0);
    end
    en = 1'b0; rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("idle_oe", oe_n, 1); chk("idle_sclk", sclk, 0); chk("idle_lat", lat, 0);
      chk("idle_re", mem_re, 0); chk("idle_ra", row_addr, 0);
    end

    // free-run three frames
    fd_log = 1; en = 1'b1;
    for (t = 0; t < 400 && fdq.size() < 3; t++) @(negedge clk);
    chk("frame_timeout", fdq.size() >= 3, 1);
    fd_log = 0;
    for (int i = 1; i < fdq.size(); i++) chk("frame_period", fdq[i] - fdq[i-1], 80);

    // drop en at the second column of row 1, plane 0
    for (t = 0; t < 300 && !(mr == 1 && mp == 0 && sclk_cnt == 1); t++) @(negedge clk);
    chk("drop_timeout", t < 300, 1);
    en = 1'b0;
    pd = planes_done;
    for (t = 0; t < 100 && planes_done == pd; t++) @(negedge clk);
    chk("finish_timeout", t < 100, 1);
    n0 = rd_total;
    repeat ($urandom_range(10, 30)) begin
      @(negedge clk);
      chk("stop_oe", oe_n, 1); chk("stop_sclk", sclk, 0);
    end
    chk("stop_reads", rd_total - n0, 0);
    chk("stop_ra", row_addr, 1);
    en = 1'b1;
    for (t = 0; t < 10 && !mem_re; t++) @(negedge clk);
    chk("resume_timeout", t < 10, 1);
    chk("resume_addr", mem_addr, 4);
    pd = planes_done;
    for (t = 0; t < 100 && planes_done == pd; t++) @(negedge clk);
    chk("resume_plane_timeout", t < 100, 1);

    // reset in the middle of SHOW
    for (t = 0; t < 200 && oe_n; t++) @(negedge clk);
    chk("show_timeout", t < 200, 1);
    #1 rst = 1'b0;
    #1;
    chk("async_oe", oe_n, 1); chk("async_re", mem_re, 0); chk("async_sclk", sclk, 0);
    chk("async_ra", row_addr, 0); chk("async_rgb", {r0, g0, b0, r1, g1, b1}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (t = 0; t < 10 && !mem_re; t++) @(negedge clk);
    chk("restart_timeout", t < 10, 1);
    chk("restart_addr", mem_addr, 0);
    for (t = 0; t < 200 && !frame_done; t++) @(negedge clk);
    chk("restart_frame_timeout", t < 200, 1);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
